// File: rtl/axi_mem_master_if.sv
// axi_mem_master_if: CPU request/response handshake plus the five AXI4 master
// channels used by axi_mem_master.
interface axi_mem_master_if;
  // CPU-side request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  // CPU-side response
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // AXI write address
  logic        io_master_awvalid;
  logic        io_master_awready;
  logic [3:0]  io_master_awid;
  logic [31:0] io_master_awaddr;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  // AXI write data
  logic        io_master_wvalid;
  logic        io_master_wready;
  logic [63:0] io_master_wdata;
  logic [7:0]  io_master_wstrb;
  logic        io_master_wlast;
  // AXI write response
  logic        io_master_bvalid;
  logic        io_master_bready;
  logic [3:0]  io_master_bid;
  logic [1:0]  io_master_bresp;
  // AXI read address
  logic        io_master_arvalid;
  logic        io_master_arready;
  logic [3:0]  io_master_arid;
  logic [31:0] io_master_araddr;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  // AXI read data
  logic        io_master_rvalid;
  logic        io_master_rready;
  logic [3:0]  io_master_rid;
  logic [63:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic        io_master_rlast;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output io_master_awvalid, io_master_awid, io_master_awaddr, io_master_awlen,
           io_master_awsize, io_master_awburst,
    input  io_master_awready,
    output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    input  io_master_wready,
    input  io_master_bvalid, io_master_bid, io_master_bresp,
    output io_master_bready,
    output io_master_arvalid, io_master_arid, io_master_araddr, io_master_arlen,
           io_master_arsize, io_master_arburst,
    input  io_master_arready,
    input  io_master_rvalid, io_master_rid, io_master_rdata, io_master_rresp,
           io_master_rlast,
    output io_master_rready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  io_master_awvalid, io_master_awid, io_master_awaddr, io_master_awlen,
           io_master_awsize, io_master_awburst,
    output io_master_awready,
    input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    output io_master_wready,
    output io_master_bvalid, io_master_bid, io_master_bresp,
    input  io_master_bready,
    input  io_master_arvalid, io_master_arid, io_master_araddr, io_master_arlen,
           io_master_arsize, io_master_arburst,
    output io_master_arready,
    output io_master_rvalid, io_master_rid, io_master_rdata, io_master_rresp,
           io_master_rlast,
    input  io_master_rready
  );
endinterface

// File: rtl/axi_mem_master.sv
// axi_mem_master: turns single CPU load/store requests into single-beat AXI4
// transactions on a 64-bit bus, with exactly one transaction in flight.
module axi_mem_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input logic              clock,
  input logic              reset,
  axi_mem_master_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  logic [2:0]  state_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [2:0]  size_r;
  logic [31:0] wdata_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        bready_r;

  logic [5:0]  shamt_s;
  logic [63:0] rshift_s;
  logic [31:0] rdata_ext_s;
  logic        req_fire_s;
  logic        size_ok_s;
  logic        aw_left_s;
  logic        w_left_s;
  logic        unused_s;

  // Byte-enable pattern for a transfer of the given size at the given lane.
  function automatic logic [7:0] strb_for(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  assign req_fire_s = bus.req_valid & req_ready_r;
  assign size_ok_s  = (bus.req_size <= 3'd2);
  // A channel is still pending after this edge if its valid is up and not accepted.
  assign aw_left_s  = awvalid_r & ~bus.io_master_awready;
  assign w_left_s   = wvalid_r & ~bus.io_master_wready;

  // Lane shift and size-based zero extension of the returned read beat.
  always_comb begin
    shamt_s  = {addr_r[2:0], 3'b000};
    rshift_s = bus.io_master_rdata >> shamt_s;
    case (size_r)
      3'd0:    rdata_ext_s = {24'h000000, rshift_s[7:0]};
      3'd1:    rdata_ext_s = {16'h0000, rshift_s[15:0]};
      default: rdata_ext_s = rshift_s[31:0];
    endcase
  end

  // IDs, last flags and upper lanes of the shifted beat carry no information here.
  assign unused_s = ^{bus.io_master_rid, bus.io_master_bid, bus.io_master_rlast,
                      rshift_s[63:32], we_r};

  assign bus.req_ready         = req_ready_r;
  assign bus.rsp_valid         = rsp_valid_r;
  assign bus.rsp_rdata         = rsp_rdata_r;
  assign bus.rsp_err           = rsp_err_r;
  assign bus.io_master_awvalid = awvalid_r;
  assign bus.io_master_awid    = AXI_ID;
  assign bus.io_master_awaddr  = addr_r;
  assign bus.io_master_awlen   = 8'h00;
  assign bus.io_master_awsize  = size_r;
  assign bus.io_master_awburst = 2'b01;
  assign bus.io_master_wvalid  = wvalid_r;
  assign bus.io_master_wdata   = {32'h00000000, wdata_r} << shamt_s;
  assign bus.io_master_wstrb   = strb_for(size_r, addr_r[2:0]);
  assign bus.io_master_wlast   = wvalid_r;
  assign bus.io_master_bready  = bready_r;
  assign bus.io_master_arvalid = arvalid_r;
  assign bus.io_master_arid    = AXI_ID;
  assign bus.io_master_araddr  = addr_r;
  assign bus.io_master_arlen   = 8'h00;
  assign bus.io_master_arsize  = size_r;
  assign bus.io_master_arburst = 2'b01;
  assign bus.io_master_rready  = rready_r;

  // Transaction FSM: latches the request, sequences AXI channels, holds the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      addr_r      <= 32'h00000000;
      size_r      <= 3'd0;
      wdata_r     <= 32'h00000000;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h00000000;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          req_ready_r <= 1'b1;
          if (req_fire_s) begin
            req_ready_r <= 1'b0;
            we_r        <= bus.req_we;
            addr_r      <= bus.req_addr;
            size_r      <= bus.req_size;
            wdata_r     <= bus.req_wdata;
            rsp_rdata_r <= 32'h00000000;
            rsp_err_r   <= 1'b0;
            if (!size_ok_s) begin
              // Illegal size is answered locally without touching the bus.
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              state_r     <= ST_RESP;
            end else if (bus.req_we) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= ST_WR_REQ;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (bus.io_master_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (bus.io_master_rvalid) begin
            rready_r    <= 1'b0;
            rsp_rdata_r <= rdata_ext_s;
            rsp_err_r   <= (bus.io_master_rresp != 2'b00);
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_WR_REQ: begin
          if (awvalid_r && bus.io_master_awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && bus.io_master_wready) begin
            wvalid_r <= 1'b0;
          end
          if (!aw_left_s && !w_left_s) begin
            bready_r <= 1'b1;
            state_r  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bus.io_master_bvalid) begin
            bready_r    <= 1'b0;
            rsp_err_r   <= (bus.io_master_bresp != 2'b00);
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_master.sv
// tb_axi_mem_master: drives CPU requests and plays the AXI slave with random
// latencies; expectations come from a byte-lane reference model.
module tb_axi_mem_master;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   aw_cnt = 0;
  int   w_cnt  = 0;
  int   ar_cnt = 0;

  axi_mem_master_if bus ();

  axi_mem_master #(.AXI_ID(4'h5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Count accepted AW, W and AR beats.
  always @(posedge clock) begin
    if (bus.io_master_awvalid === 1'b1 && bus.io_master_awready === 1'b1) aw_cnt <= aw_cnt + 1;
    if (bus.io_master_wvalid === 1'b1 && bus.io_master_wready === 1'b1) w_cnt <= w_cnt + 1;
    if (bus.io_master_arvalid === 1'b1 && bus.io_master_arready === 1'b1) ar_cnt <= ar_cnt + 1;
  end

  // Read result: bytes starting at lane addr%8, as many as the size says, zero above.
  function automatic logic [31:0] ref_rdata(input logic [63:0] d, input logic [31:0] a,
                                            input logic [2:0] s);
    logic [31:0] r;
    int off;
    int nb;
    r = 32'h0;
    off = int'(a % 32'd8);
    nb = 1 << s;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) r[8*i +: 8] = d[8*(off+i) +: 8];
    return r;
  endfunction

  // Write data: all four request bytes placed from lane addr%8 upward, dropping overflow.
  function automatic logic [63:0] ref_wdata(input logic [31:0] wd, input logic [31:0] a);
    logic [63:0] v;
    int off;
    v = 64'h0;
    off = int'(a % 32'd8);
    for (int i = 0; i < 4; i++)
      if (off + i < 8) v[8*(off+i) +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  // Byte enables: one per transferred byte from lane addr%8 upward.
  function automatic logic [7:0] ref_wstrb(input logic [31:0] a, input logic [2:0] s);
    logic [7:0] m;
    int off;
    m = 8'h00;
    off = int'(a % 32'd8);
    for (int i = 0; i < (1 << s); i++)
      if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  task automatic issue_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wd);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait got %b exp 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wd;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic check_resp(input logic [31:0] exp_d, input logic exp_e, input int hold,
                            input string tag);
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_d || bus.rsp_err !== exp_e) begin
        errors++;
        $display("FAIL %s_rsp cyc %0d got v=%b d=%h e=%b exp v=1 d=%h e=%b", tag, i,
                 bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, exp_d, exp_e);
      end
      checks++;
      if (bus.req_ready !== 1'b0 || bus.io_master_arvalid !== 1'b0 ||
          bus.io_master_awvalid !== 1'b0 || bus.io_master_wvalid !== 1'b0 ||
          bus.io_master_rready !== 1'b0 || bus.io_master_bready !== 1'b0) begin
        errors++;
        $display("FAIL %s_resp_quiet cyc %0d got rq=%b ar=%b aw=%b w=%b r=%b b=%b exp all 0",
                 tag, i, bus.req_ready, bus.io_master_arvalid, bus.io_master_awvalid,
                 bus.io_master_wvalid, bus.io_master_rready, bus.io_master_bready);
      end
      bus.rsp_ready = (i == hold);
      @(negedge clock);
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_rsp got v=%b rq=%b exp v=0 rq=1", tag, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [2:0] size, input int ar_delay,
                          input int r_delay, input logic [63:0] rdata, input logic [1:0] rresp,
                          input int hold);
    int a0;
    a0 = ar_cnt;
    issue_req(1'b0, addr, size, 32'h0);
    for (int i = 0; i <= ar_delay; i++) begin
      checks++;
      if (bus.io_master_arvalid !== 1'b1 || bus.io_master_araddr !== addr ||
          bus.io_master_arsize !== size || bus.io_master_arlen !== 8'h00 ||
          bus.io_master_arburst !== 2'b01 || bus.io_master_arid !== 4'h5 ||
          bus.io_master_rready !== 1'b0) begin
        errors++;
        $display("FAIL rd_ar cyc %0d got v=%b a=%h s=%0d l=%h b=%b id=%h rr=%b exp v=1 a=%h s=%0d",
                 i, bus.io_master_arvalid, bus.io_master_araddr, bus.io_master_arsize,
                 bus.io_master_arlen, bus.io_master_arburst, bus.io_master_arid,
                 bus.io_master_rready, addr, size);
      end
      bus.io_master_arready = (i == ar_delay);
      @(negedge clock);
    end
    bus.io_master_arready = 1'b0;
    for (int i = 0; i <= r_delay; i++) begin
      checks++;
      if (bus.io_master_arvalid !== 1'b0 || bus.io_master_rready !== 1'b1) begin
        errors++;
        $display("FAIL rd_wait cyc %0d got ar=%b rr=%b exp ar=0 rr=1", i,
                 bus.io_master_arvalid, bus.io_master_rready);
      end
      if (i == r_delay) begin
        bus.io_master_rvalid = 1'b1;
        bus.io_master_rdata  = rdata;
        bus.io_master_rresp  = rresp;
        bus.io_master_rid    = 4'($urandom);
      end
      @(negedge clock);
    end
    bus.io_master_rvalid = 1'b0;
    bus.io_master_rdata  = {$urandom, $urandom};
    check_resp(ref_rdata(rdata, addr, size), (rresp != 2'b00), hold, "rd");
    checks++;
    if (ar_cnt - a0 !== 1) begin
      errors++;
      $display("FAIL rd_ar_beats got %0d exp 1", ar_cnt - a0);
    end
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd,
                           input int aw_delay, input int w_delay, input int b_delay,
                           input logic [1:0] bresp, input int hold);
    int  a0;
    int  w0;
    int  c;
    bit  aw_done;
    bit  w_done;
    a0 = aw_cnt;
    w0 = w_cnt;
    c = 0;
    aw_done = 1'b0;
    w_done = 1'b0;
    issue_req(1'b1, addr, size, wd);
    while (!(aw_done && w_done) && c < 64) begin
      checks++;
      if (bus.io_master_awvalid !== !aw_done || bus.io_master_wvalid !== !w_done ||
          bus.io_master_bready !== 1'b0) begin
        errors++;
        $display("FAIL wr_valids cyc %0d got aw=%b w=%b b=%b exp aw=%b w=%b b=0", c,
                 bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready,
                 !aw_done, !w_done);
      end
      if (!aw_done) begin
        checks++;
        if (bus.io_master_awaddr !== addr || bus.io_master_awsize !== size ||
            bus.io_master_awlen !== 8'h00 || bus.io_master_awburst !== 2'b01 ||
            bus.io_master_awid !== 4'h5) begin
          errors++;
          $display("FAIL wr_aw got a=%h s=%0d l=%h b=%b id=%h exp a=%h s=%0d", bus.io_master_awaddr,
                   bus.io_master_awsize, bus.io_master_awlen, bus.io_master_awburst,
                   bus.io_master_awid, addr, size);
        end
      end
      if (!w_done) begin
        checks++;
        if (bus.io_master_wdata !== ref_wdata(wd, addr) ||
            bus.io_master_wstrb !== ref_wstrb(addr, size) || bus.io_master_wlast !== 1'b1) begin
          errors++;
          $display("FAIL wr_w got d=%h s=%h l=%b exp d=%h s=%h l=1", bus.io_master_wdata,
                   bus.io_master_wstrb, bus.io_master_wlast, ref_wdata(wd, addr),
                   ref_wstrb(addr, size));
        end
      end
      bus.io_master_awready = (c == aw_delay);
      bus.io_master_wready  = (c == w_delay);
      @(negedge clock);
      if (c == aw_delay) aw_done = 1'b1;
      if (c == w_delay) w_done = 1'b1;
      c++;
    end
    bus.io_master_awready = 1'b0;
    bus.io_master_wready  = 1'b0;
    for (int i = 0; i <= b_delay; i++) begin
      checks++;
      if (bus.io_master_awvalid !== 1'b0 || bus.io_master_wvalid !== 1'b0 ||
          bus.io_master_bready !== 1'b1) begin
        errors++;
        $display("FAIL wr_bwait cyc %0d got aw=%b w=%b b=%b exp aw=0 w=0 b=1", i,
                 bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready);
      end
      if (i == b_delay) begin
        bus.io_master_bvalid = 1'b1;
        bus.io_master_bresp  = bresp;
        bus.io_master_bid    = 4'($urandom);
      end
      @(negedge clock);
    end
    bus.io_master_bvalid = 1'b0;
    check_resp(32'h0, (bresp != 2'b00), hold, "wr");
    checks++;
    if (aw_cnt - a0 !== 1 || w_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL wr_beats got aw=%0d w=%0d exp 1 1", aw_cnt - a0, w_cnt - w0);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
    bus.req_size = 3'd0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
    bus.io_master_awready = 1'b0; bus.io_master_wready = 1'b0;
    bus.io_master_bvalid = 1'b0; bus.io_master_bid = 4'h0; bus.io_master_bresp = 2'b00;
    bus.io_master_arready = 1'b0; bus.io_master_rvalid = 1'b0; bus.io_master_rid = 4'h0;
    bus.io_master_rdata = 64'h0; bus.io_master_rresp = 2'b00; bus.io_master_rlast = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
        bus.rsp_err !== 1'b0 || bus.io_master_arvalid !== 1'b0 || bus.io_master_awvalid !== 1'b0 ||
        bus.io_master_wvalid !== 1'b0 || bus.io_master_rready !== 1'b0 ||
        bus.io_master_bready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rq=%b v=%b d=%h e=%b ar=%b aw=%b w=%b r=%b b=%b exp 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.io_master_arvalid,
               bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_rready,
               bus.io_master_bready);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", bus.req_ready);
    end
  endtask

  task automatic test_read_word();
    run_read(32'h8000_0004, 3'd2, 2, 1, 64'h11223344_AABBCCDD, 2'b00, 0);
  endtask

  task automatic test_write_byte();
    run_write(32'h8000_0003, 3'd0, 32'h0000_00EF, 0, 0, 1, 2'b00, 0);
  endtask

  task automatic test_write_w_first();
    run_write(32'h8000_0006, 3'd1, 32'h0000_BEEF, 3, 0, 0, 2'b00, 1);
  endtask

  task automatic test_err_resp();
    run_read(32'h8000_0010, 3'd2, 0, 0, {$urandom, $urandom}, 2'b10, 0);
    run_write(32'h8000_0020, 3'd2, $urandom, 1, 1, 2, 2'b11, 0);
  endtask

  task automatic test_rsp_hold();
    run_read(32'h8000_0101, 3'd0, 1, 2, {$urandom, $urandom}, 2'b00, 5);
  endtask

  task automatic test_illegal_size();
    int a0;
    int r0;
    a0 = aw_cnt;
    r0 = ar_cnt;
    issue_req(1'b1, 32'h8000_0040, 3'($urandom_range(7, 3)), $urandom);
    check_resp(32'h0, 1'b1, 5, "illegal");
    checks++;
    if (aw_cnt !== a0 || ar_cnt !== r0) begin
      errors++;
      $display("FAIL illegal_no_traffic got aw=%0d ar=%0d exp 0 0", aw_cnt - a0, ar_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    a0 = aw_cnt;
    issue_req(1'b1, 32'h8000_0008, 3'd2, 32'hCAFE_F00D);
    checks++;
    if (bus.io_master_awvalid !== 1'b1 || bus.io_master_wvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_before got aw=%b w=%b exp 1 1", bus.io_master_awvalid, bus.io_master_wvalid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.io_master_awvalid !== 1'b0 || bus.io_master_wvalid !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got aw=%b w=%b v=%b rq=%b exp 0 0 0 0", bus.io_master_awvalid,
               bus.io_master_wvalid, bus.rsp_valid, bus.req_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.rsp_valid !== 1'b0 || aw_cnt !== a0) begin
      errors++;
      $display("FAIL mid_abandon got v=%b aw=%0d exp 0 0", bus.rsp_valid, aw_cnt - a0);
    end
    run_read(32'h8000_0002, 3'd1, 1, 0, {$urandom, $urandom}, 2'b00, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  resp;
      addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      size = 3'($urandom_range(2, 0));
      resp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      if ($urandom_range(1, 0) == 1)
        run_write(addr, size, $urandom, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(2, 0), resp, $urandom_range(2, 0));
      else
        run_read(addr, size, $urandom_range(3, 0), $urandom_range(3, 0), {$urandom, $urandom},
                 resp, $urandom_range(2, 0));
    end
  endtask

  initial begin
    test_reset();
    test_read_word();
    test_write_byte();
    test_write_w_first();
    test_err_resp();
    test_rsp_hold();
    test_illegal_size();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

endmodule
